speed_uart_tx: RTL and testbench

Downstream serializer for the vehicle speed-measurement datapath. Accepts one completed measurement record (speed plus E-pass flag) from the speed calculator and transmits it on serial_data_out as a 4-byte UART 8N1 packet. A one-deep holding buffer decouples the measurement pipeline from the slow serial line.

---
 rtl/speed_uart_tx.sv | 159 +++++++++++++++
 tb/tb_speed_uart_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/speed_uart_tx.sv
// Serializes one speed record into a 4-byte UART 8N1 packet: header 0xA5, flag/speed-high, speed-low, XOR checksum.
// A one-deep holding buffer lets the next record wait while the current packet is on the line.
module speed_uart_tx #(
  parameter int WIDTH_SPEED  = 14,
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH_SPEED-1:0] speed,
  input  logic                   epass,
  output logic                   serial_data_out,
  output logic                   busy,
  output logic                   packet_done,
  output logic                   overrun
);

  localparam int              TW     = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]   T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]      HEADER = 8'hA5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [23:0]   pkt_q, pkt_d;
  logic [14:0]   hold_q, hold_d;
  logic          pending_q, pending_d;
  logic          serial_q, serial_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          over_q, over_d;

  logic [13:0]   speed_ext;
  logic [7:0]    byte1, byte2, byte3;
  logic          timer_last;

  always_comb begin
    speed_ext = '0;
    speed_ext[WIDTH_SPEED-1:0] = speed;
  end

  assign byte1      = {hold_q[14], 1'b0, hold_q[13:8]};
  assign byte2      = hold_q[7:0];
  assign byte3      = HEADER ^ byte1 ^ byte2;
  assign timer_last = (timer_q == T_LAST);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_last ? '0 : timer_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    pkt_d      = pkt_q;
    hold_d     = hold_q;
    pending_d  = pending_q;
    serial_d   = serial_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    over_d     = in_valid && pending_q;

    // Accept and load are mutually exclusive: accept needs pending low, load needs it high.
    if (in_valid && !pending_q) begin
      pending_d = 1'b1;
      hold_d    = {epass, speed_ext};
    end

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (pending_q) begin
          pending_d  = 1'b0;
          shift_d    = HEADER;
          pkt_d      = {byte3, byte2, byte1};
          byte_idx_d = 2'd0;
          serial_d   = 1'b0;
          busy_d     = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        if (timer_last) begin
          bit_idx_d = 3'd0;
          serial_d  = shift_q[0];
          state_d   = DATA;
        end
      end
      DATA: begin
        if (timer_last) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            serial_d = 1'b1;
            state_d  = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            serial_d  = shift_q[1];
          end
        end
      end
      STOP: begin
        if (timer_last) begin
          if (byte_idx_q == 2'd3) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = pkt_q[7:0];
            pkt_d      = {8'h00, pkt_q[23:8]};
            serial_d   = 1'b0;
            state_d    = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      pkt_q      <= '0;
      hold_q     <= '0;
      pending_q  <= 1'b0;
      serial_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      pkt_q      <= pkt_d;
      hold_q     <= hold_d;
      pending_q  <= pending_d;
      serial_q   <= serial_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      over_q     <= over_d;
    end
  end

  assign in_ready        = !pending_q;
  assign serial_data_out = serial_q;
  assign busy            = busy_q;
  assign packet_done     = done_q;
  assign overrun         = over_q;

endmodule

// File: tb/tb_speed_uart_tx.sv
// Bench for speed_uart_tx: a packet-level line model checked every cycle, a mid-bit UART decoder,
// and literal byte/latency expectations for directed records.
module tb_speed_uart_tx;
  localparam int CPB = 4;
  localparam int W   = 14;
  localparam int PKT = 40 * CPB;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         epass = 1'b0;
  logic [W-1:0] speed = '0;
  logic         in_ready, serial_data_out, busy, packet_done, overrun;

  speed_uart_tx #(.WIDTH_SPEED(W), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .speed(speed), .epass(epass), .serial_data_out(serial_data_out),
    .busy(busy), .packet_done(packet_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] pkt_byte(input logic [13:0] s, input bit e, input int k);
    logic [7:0] b1, b2;
    b1 = {e, 1'b0, s[13:8]};
    b2 = s[7:0];
    case (k)
      0:       return 8'hA5;
      1:       return b1;
      2:       return b2;
      default: return 8'hA5 ^ b1 ^ b2;
    endcase
  endfunction

  // Line model: a packet is a 40-bit frame; the line shows frame[cnt/CPB] for 40*CPB cycles.
  bit          m_valid = 0;
  bit          m_active = 0;
  int          m_cnt = 0;
  bit          m_frame [0:39];
  bit          m_pending = 0;
  bit          m_was_pending = 0;
  logic [13:0] m_hspeed = '0;
  bit          m_hepass = 0;
  bit          m_done = 0;
  bit          m_over = 0;
  logic [7:0]  m_b;
  logic [7:0]  m_bytes[$];
  logic [7:0]  dec_q[$];

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_valid   = 1;
      m_active  = 0;
      m_cnt     = 0;
      m_pending = 0;
      m_done    = 0;
      m_over    = 0;
    end else begin
      m_was_pending = m_pending;
      m_done = 0;
      m_over = in_valid && m_was_pending;
      if (m_active) begin
        m_cnt++;
        if (m_cnt == PKT) begin
          m_active = 0;
          m_done   = 1;
        end
      end else if (m_was_pending) begin
        for (int k = 0; k < 4; k++) begin
          m_b = pkt_byte(m_hspeed, m_hepass, k);
          m_bytes.push_back(m_b);
          m_frame[k*10] = 1'b0;
          for (int j = 0; j < 8; j++) m_frame[k*10+1+j] = m_b[j];
          m_frame[k*10+9] = 1'b1;
        end
        m_active  = 1;
        m_cnt     = 0;
        m_pending = 0;
      end
      if (in_valid && !m_was_pending) begin
        m_pending = 1;
        m_hspeed  = 14'(speed);
        m_hepass  = epass;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("serial", serial_data_out, m_active ? m_frame[m_cnt / CPB] : 1'b1);
      chk("busy", busy, m_active);
      chk("in_ready", in_ready, !m_pending);
      chk("packet_done", packet_done, m_done);
      chk("overrun", overrun, m_over);
    end
  end

  // Receiver: samples each bit at its middle cycle, independent of the model.
  bit         dec_busy = 0;
  int         dec_t = 0;
  logic [7:0] dec_sh = '0;
  int         ov_seen = 0;

  always @(negedge clk) begin
    if (overrun === 1'b1) ov_seen++;
    if (reset) begin
      dec_busy = 0;
    end else if (!dec_busy) begin
      if (serial_data_out === 1'b0) begin
        dec_busy = 1;
        dec_t    = 0;
      end
    end else begin
      dec_t++;
      if (dec_t == 9*CPB + CPB/2) begin
        chk("stop_bit", serial_data_out, 1'b1);
        dec_q.push_back(dec_sh);
        dec_busy = 0;
      end else if (dec_t == CPB/2) begin
        chk("start_bit", serial_data_out, 1'b0);
      end else if (dec_t % CPB == CPB/2) begin
        dec_sh = {serial_data_out, dec_sh[7:1]};
      end
    end
  end

  task automatic send(input logic [13:0] s, input bit e);
    @(posedge clk); #1;
    speed    = W'(s);
    epass    = e;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_bytes(input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp [4];
    logic [7:0] got [4];
    logic [7:0] mdl;
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int k = 0; k < 4; k++) begin
      got[k] = (dec_q.size() > 0) ? dec_q.pop_front() : 8'hxx;
      mdl    = (m_bytes.size() > 0) ? m_bytes.pop_front() : 8'hxx;
      chk("line_byte", got[k], exp[k]);
      chk("model_byte", mdl, exp[k]);
    end
    $display("packet at cycle %0d: %02h %02h %02h %02h", cyc, got[0], got[1], got[2], got[3]);
  endtask

  initial begin
    int t0, t_start, t_done, ov0;
    // Reset and idle
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_serial", serial_data_out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    chk("idle_serial", serial_data_out, 1'b1);
    chk("idle_ready", in_ready, 1'b1);

    // Single record: latency and packet length
    @(posedge clk); #1;
    speed = W'(14'd1234); epass = 1'b1; in_valid = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    t_start = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (serial_data_out === 1'b0) begin t_start = cyc; break; end
    end
    t_done = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (packet_done === 1'b1) begin t_done = cyc; break; end
    end
    chk("start_latency", 32'(t_start - t0), 32'd2);
    chk("packet_length", 32'(t_done - t_start), 32'(PKT));
    repeat (20) @(posedge clk);
    check_bytes(8'hA5, 8'h84, 8'hD2, 8'hF3);

    // All-ones speed, no E-pass
    send(14'h3FFF, 1'b0);
    repeat (PKT + 20) @(posedge clk);
    check_bytes(8'hA5, 8'h3F, 8'hFF, 8'h65);

    // Three records 10 cycles apart: one sends, one queues, one overruns
    ov0 = ov_seen;
    send(14'd100, 1'b1);
    repeat (8) @(posedge clk);
    send(14'h1ABC, 1'b0);
    chk("queued_not_ready", in_ready, 1'b0);
    repeat (8) @(posedge clk);
    send(14'h0555, 1'b1);
    repeat (2*PKT + 40) @(posedge clk);
    chk("overrun_count", 32'(ov_seen - ov0), 32'd1);
    check_bytes(8'hA5, 8'h80, 8'h64, 8'h41);
    check_bytes(8'hA5, 8'h1A, 8'hBC, 8'h03);
    chk("third_dropped", 32'(dec_q.size()), 32'd0);

    // Reset during B1 data bits with a record queued
    send(14'h0200, 1'b1);
    repeat (5) @(posedge clk);
    send(14'h0077, 1'b0);
    repeat (40) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_serial", serial_data_out, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", in_ready, 1'b1);
    dec_q.delete();
    m_bytes.delete();
    repeat (PKT + 20) @(posedge clk);
    chk("queued_lost", 32'(dec_q.size()), 32'd0);
    send(14'd60, 1'b1);
    repeat (PKT + 20) @(posedge clk);
    check_bytes(8'hA5, 8'h80, 8'h3C, 8'h19);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
